press_decoder: RTL

PRESS_DECODER -- requirements
Module: press_decoder

---
 rtl/press_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/press_decoder.sv
// press_decoder: turns single-cycle press pulses into single/double click
// events using a free-running tick prescaler, a double-click window and a
// post-double lockout. Outputs are registered; event counters saturate.
module press_decoder #(
   parameter int TICK_DIV     = 1000,
   parameter int WINDOW_TICKS = 50,
   parameter int LOCK_TICKS   = 25
) (
   input  logic       clk5,
   input  logic       reset,
   input  logic       press,
   output logic       single,
   output logic       double,
   output logic       busy,
   output logic [7:0] single_count,
   output logic [7:0] double_count
);

   // Prescaler width; a divide of 1 still needs a 1-bit register.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // Shared window/lockout counter is sized for the longer of the two.
   localparam int MAX_TICKS = (WINDOW_TICKS > LOCK_TICKS) ? WINDOW_TICKS : LOCK_TICKS;
   localparam int WW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW_TICKS - 1);
   localparam logic [WW-1:0] LOCK_LAST  = WW'(LOCK_TICKS - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_LOCKOUT = 2'd2;

   logic [PW-1:0] presc;
   logic          tick;
   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [WW-1:0] win_cnt;
   logic [WW-1:0] next_win;
   logic          set_single;
   logic          set_double;

   assign tick = (presc == PRESC_LAST);

   // Free-running prescaler, independent of the FSM state.
   always_ff @(posedge clk5 or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Next-state logic; a press in WAIT takes priority over window expiry,
   // and LOCKOUT never looks at press (including on its exit cycle).
   always_comb begin
      next_state = state;
      next_win   = win_cnt;
      set_single = 1'b0;
      set_double = 1'b0;
      case (state)
         ST_IDLE: begin
            if (press) begin
               next_state = ST_WAIT;
               next_win   = '0;
            end
         end
         ST_WAIT: begin
            if (press) begin
               next_state = ST_LOCKOUT;
               next_win   = '0;
               set_double = 1'b1;
            end else if (tick) begin
               if (win_cnt == WIN_LAST) begin
                  next_state = ST_IDLE;
                  next_win   = '0;
                  set_single = 1'b1;
               end else begin
                  next_win = win_cnt + 1'b1;
               end
            end
         end
         ST_LOCKOUT: begin
            if (tick) begin
               if (win_cnt == LOCK_LAST) begin
                  next_state = ST_IDLE;
                  next_win   = '0;
               end else begin
                  next_win = win_cnt + 1'b1;
               end
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_win   = '0;
         end
      endcase
   end

   // State, counter and registered event outputs; busy mirrors the new state.
   always_ff @(posedge clk5 or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         win_cnt      <= '0;
         single       <= 1'b0;
         double       <= 1'b0;
         busy         <= 1'b0;
         single_count <= 8'd0;
         double_count <= 8'd0;
      end else begin
         state   <= next_state;
         win_cnt <= next_win;
         single  <= set_single;
         double  <= set_double;
         busy    <= (next_state != ST_IDLE);
         if (set_single && (single_count != 8'hFF)) begin
            single_count <= single_count + 8'd1;
         end
         if (set_double && (double_count != 8'hFF)) begin
            double_count <= double_count + 8'd1;
         end
      end
   end

endmodule
